// File: rtl/defs_pkg.sv
// Shared definitions for the memory-access stage: load/store widths,
// memory trap causes and the bus transaction FSM state.
package defs_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } mem_funct3_e;

    localparam logic [3:0] MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] LOAD_FAULT       = 4'd5;
    localparam logic [3:0] MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] STORE_FAULT      = 4'd7;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_RESP
    } mem_state_e;

    // funct3[1:0] encodes log2 of the access size in bytes
    function automatic logic [3:0] access_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: store shift and byte enables,
// load extraction with sign/zero extension, and misaligned/illegal detection.
module mem_align
    import defs_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_data,
    input  logic [2:0]        funct3,
    input  logic              is_store,
    output logic [XLEN-1:0]   lane_addr,
    output logic [XLEN-1:0]   store_wdata,
    output logic [XLEN/8-1:0] store_be,
    output logic [XLEN-1:0]   load_value,
    output logic              fault
);

    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);

    logic [OFF_W-1:0] offset;
    logic [2:0]       offset3;
    logic [3:0]       nbytes;
    logic [2:0]       size_mask;
    logic             illegal;
    logic [LANES-1:0] width_mask;
    logic [XLEN-1:0]  shifted;

    assign offset    = addr[OFF_W-1:0];
    assign offset3   = 3'(offset);
    assign nbytes    = access_bytes(funct3[1:0]);
    assign size_mask = 3'(nbytes - 4'd1);
    assign lane_addr = {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign width_mask[gi] = (4'(gi) < nbytes);
        end
    endgenerate

    assign store_wdata = store_data << {offset, 3'b000};
    assign store_be    = width_mask << offset;
    assign shifted     = load_data >> {offset, 3'b000};

    // Doubleword and unsigned-word accesses only exist on a 64-bit datapath
    always_comb begin
        illegal = (funct3 == 3'b111) || (is_store && funct3[2]);
        if (XLEN == 32 && (funct3 == F3_D || funct3 == F3_WU)) begin
            illegal = 1'b1;
        end
        fault = illegal || ((offset3 & size_mask) != 3'd0);
    end

    always_comb begin
        load_value = shifted;
        case (funct3)
            F3_B:    load_value = XLEN'($signed(shifted[7:0]));
            F3_H:    load_value = XLEN'($signed(shifted[15:0]));
            F3_W:    load_value = XLEN'($signed(shifted[31:0]));
            F3_BU:   load_value = XLEN'(shifted[7:0]);
            F3_HU:   load_value = XLEN'(shifted[15:0]);
            F3_WU:   load_value = XLEN'(shifted[31:0]);
            default: load_value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on a req/gnt/rvalid port,
// stalls upstream while a transaction is outstanding, and registers MEM/WB.
module mem_access
    import defs_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic              reg_write_enable,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              trap_in,
    input  logic [3:0]        trap_cause_in,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_err,
    output logic              stall_req,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        rd_out,
    output logic              reg_write_enable_out,
    output logic [XLEN-1:0]   pc_out,
    output logic              trap_out,
    output logic [3:0]        trap_cause_out,
    output logic [XLEN-1:0]   trap_val_out
);

    localparam int LANES = XLEN / 8;

    mem_state_e       state_reg, state_next;
    logic             kill_reg, kill_next;
    logic [XLEN-1:0]  addr_reg, wdata_reg, pc_reg;
    logic [LANES-1:0] be_reg;
    logic             we_reg;
    logic [4:0]       rd_reg;
    logic [2:0]       funct3_reg;

    logic             is_idle, mem_op, launch, misaligned_op, resp_done, bus_req;
    logic [XLEN-1:0]  align_addr, lane_addr, store_wdata, load_value;
    logic [LANES-1:0] store_be;
    logic [2:0]       align_funct3;
    logic             align_store, align_fault;

    logic [XLEN-1:0]  wb_data_next, pc_next, tval_next;
    logic [4:0]       rd_next;
    logic             rwe_next, trap_next;
    logic [3:0]       cause_next;

    assign is_idle = (state_reg == MEM_IDLE);

    // One aligner serves both phases: live inputs while idle, latched fields after
    assign align_addr   = is_idle ? alu_result : addr_reg;
    assign align_funct3 = is_idle ? funct3     : funct3_reg;
    assign align_store  = is_idle ? mem_write  : we_reg;

    mem_align #(.XLEN(XLEN)) u_align (
        .addr        (align_addr),
        .store_data  (rs2_data),
        .load_data   (dmem_rdata),
        .funct3      (align_funct3),
        .is_store    (align_store),
        .lane_addr   (lane_addr),
        .store_wdata (store_wdata),
        .store_be    (store_be),
        .load_value  (load_value),
        .fault       (align_fault)
    );

    assign mem_op        = (mem_read || mem_write) && !trap_in && !flush;
    assign launch        = is_idle && mem_op && !align_fault;
    assign misaligned_op = is_idle && mem_op && align_fault;
    assign resp_done     = (state_reg == MEM_RESP) && dmem_rvalid;

    always_comb begin
        state_next = state_reg;
        kill_next  = kill_reg;
        bus_req    = 1'b0;
        case (state_reg)
            MEM_IDLE: begin
                kill_next = 1'b0;
                if (launch) begin
                    bus_req    = 1'b1;
                    state_next = dmem_gnt ? MEM_RESP : MEM_REQ;
                end
            end
            MEM_REQ: begin
                bus_req = 1'b1;
                if (flush) kill_next = 1'b1;
                if (dmem_gnt) state_next = MEM_RESP;
            end
            MEM_RESP: begin
                if (flush) kill_next = 1'b1;
                if (dmem_rvalid) begin
                    state_next = MEM_IDLE;
                    kill_next  = 1'b0;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    // Reset forces every combinational output low, including the live-input bus path
    assign dmem_req   = bus_req && !reset;
    assign stall_req  = !reset && (launch || (state_reg == MEM_REQ) ||
                                   ((state_reg == MEM_RESP) && !dmem_rvalid));
    assign dmem_addr  = dmem_req ? lane_addr : '0;
    assign dmem_wdata = !dmem_req ? '0 : (is_idle ? store_wdata : wdata_reg);
    assign dmem_be    = !dmem_req ? '0 : (is_idle ? store_be : be_reg);
    assign dmem_we    = dmem_req && (is_idle ? mem_write : we_reg);

    always_comb begin
        wb_data_next = '0;
        rd_next      = '0;
        rwe_next     = 1'b0;
        pc_next      = '0;
        trap_next    = 1'b0;
        cause_next   = '0;
        tval_next    = '0;
        if (is_idle && !flush && !launch) begin
            rd_next = rd;
            pc_next = pc_in;
            if (misaligned_op) begin
                trap_next  = 1'b1;
                cause_next = mem_write ? MISALIGNED_STORE : MISALIGNED_LOAD;
                tval_next  = alu_result;
            end else begin
                wb_data_next = alu_result;
                rwe_next     = reg_write_enable;
                trap_next    = trap_in;
                cause_next   = trap_cause_in;
            end
        end else if (resp_done && !kill_reg && !flush) begin
            rd_next = rd_reg;
            pc_next = pc_reg;
            if (dmem_err) begin
                trap_next  = 1'b1;
                cause_next = we_reg ? STORE_FAULT : LOAD_FAULT;
                tval_next  = addr_reg;
            end else if (!we_reg) begin
                wb_data_next = load_value;
                rwe_next     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= MEM_IDLE;
            kill_reg   <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            pc_reg     <= '0;
            be_reg     <= '0;
            we_reg     <= 1'b0;
            rd_reg     <= '0;
            funct3_reg <= '0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
            if (launch) begin
                addr_reg   <= alu_result;
                wdata_reg  <= store_wdata;
                pc_reg     <= pc_in;
                be_reg     <= store_be;
                we_reg     <= mem_write;
                rd_reg     <= rd;
                funct3_reg <= funct3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data              <= '0;
            rd_out               <= '0;
            reg_write_enable_out <= 1'b0;
            pc_out               <= '0;
            trap_out             <= 1'b0;
            trap_cause_out       <= '0;
            trap_val_out         <= '0;
        end else begin
            wb_data              <= wb_data_next;
            rd_out               <= rd_next;
            reg_write_enable_out <= rwe_next;
            pc_out               <= pc_next;
            trap_out             <= trap_next;
            trap_cause_out       <= cause_next;
            trap_val_out         <= tval_next;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a transaction-level model predicts bus and
// MEM/WB behaviour per cycle; literal checks pin key values of the model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] alu_result, rs2_data, pc_in;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_write_enable, mem_read, mem_write, trap_in, flush;
    logic [3:0]  trap_cause_in;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_be;
    logic        stall_req, reg_write_enable_out, trap_out;
    logic [63:0] wb_data, pc_out, trap_val_out;
    logic [4:0]  rd_out;
    logic [3:0]  trap_cause_out;

    always #5 clk = ~clk;

    mem_access #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .alu_result(alu_result), .rs2_data(rs2_data), .pc_in(pc_in), .rd(rd),
        .funct3(funct3), .reg_write_enable(reg_write_enable),
        .mem_read(mem_read), .mem_write(mem_write),
        .trap_in(trap_in), .trap_cause_in(trap_cause_in), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .stall_req(stall_req), .wb_data(wb_data), .rd_out(rd_out),
        .reg_write_enable_out(reg_write_enable_out), .pc_out(pc_out),
        .trap_out(trap_out), .trap_cause_out(trap_cause_out),
        .trap_val_out(trap_val_out)
    );

    typedef struct packed {
        logic [63:0] alu, rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        we, mr, mw, trap;
        logic [3:0]  cause;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic [63:0] wb;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] pc;
        logic        trap;
        logic [3:0]  cause;
        logic [63:0] tval;
    } out_t;

    typedef struct packed {
        logic        bus;
        logic [63:0] addr, wdata;
        logic [7:0]  be;
        logic        we;
    } bus_t;

    int checks = 0;
    int failures = 0;
    int txn_id = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    logic [7:0]  last_be;
    logic [63:0] last_wdata;

    logic chk_en = 1'b0;
    logic exp_stall, exp_req;
    bus_t exp_b;
    out_t exp_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result of one instruction derived from address arithmetic and width rules
    function automatic void model(input in_t i, input logic [63:0] pc, input logic [63:0] rdata,
                                  input logic err, input logic killed,
                                  output bus_t b, output out_t o);
        int off, n;
        logic st;
        logic [63:0] sh, mask, raw;
        b = '0;
        o = '0;
        if (i.flush) return;
        if (!(i.mr || i.mw) || i.trap) begin
            o.wb = i.alu; o.rd = i.rd; o.we = i.we; o.pc = pc;
            o.trap = i.trap; o.cause = i.cause;
            return;
        end
        st  = i.mw;
        off = int'(i.alu[2:0]);
        n   = 1 << i.f3[1:0];
        o.rd = i.rd;
        o.pc = pc;
        if (i.f3 == 3'd7 || (st && i.f3 > 3'd3) || (i.alu % 64'(n)) != 64'd0) begin
            o.trap = 1'b1; o.cause = st ? 4'd6 : 4'd4; o.tval = i.alu;
            return;
        end
        b.bus   = 1'b1;
        b.addr  = i.alu - 64'(off);
        b.wdata = i.rs2 << (8 * off);
        b.be    = 8'(((1 << n) - 1) << off);
        b.we    = st;
        if (killed) begin
            o = '0;
            return;
        end
        if (err) begin
            o.trap = 1'b1; o.cause = st ? 4'd7 : 4'd5; o.tval = i.alu;
            return;
        end
        if (!st) begin
            sh = rdata >> (8 * off);
            if (n == 8) raw = sh;
            else begin
                mask = (64'd1 << (8 * n)) - 64'd1;
                raw  = sh & mask;
                if (i.f3 < 3'd4 && sh[8*n-1]) raw = raw | ~mask;
            end
            o.wb = raw;
            o.we = 1'b1;
        end
    endfunction

    function automatic in_t mk(input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] r,
                               input logic [2:0] f3, input logic we, input logic mr, input logic mw);
        in_t t;
        t = '0;
        t.alu = alu; t.rs2 = rs2; t.rd = r; t.f3 = f3; t.we = we; t.mr = mr; t.mw = mw;
        return t;
    endfunction

    task automatic drive(input in_t i, input logic [63:0] pc, input logic fl);
        alu_result = i.alu; rs2_data = i.rs2; pc_in = pc; rd = i.rd; funct3 = i.f3;
        reg_write_enable = i.we; mem_read = i.mr; mem_write = i.mw;
        trap_in = i.trap; trap_cause_in = i.cause; flush = fl;
    endtask

    // Per-cycle compare against the expectations the driver publishes
    always @(negedge clk) begin
        if (chk_en) begin
            if (stall_req) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                last_be    = dmem_be;
                last_wdata = dmem_wdata;
            end
            chk("stall_req", 64'(stall_req), 64'(exp_stall));
            chk("dmem_req", 64'(dmem_req), 64'(exp_req));
            if (exp_req) begin
                chk("dmem_addr", dmem_addr, exp_b.addr);
                chk("dmem_wdata", dmem_wdata, exp_b.wdata);
                chk("dmem_be", 64'(dmem_be), 64'(exp_b.be));
                chk("dmem_we", 64'(dmem_we), 64'(exp_b.we));
            end
            chk("wb_data", wb_data, exp_o.wb);
            chk("rd_out", 64'(rd_out), 64'(exp_o.rd));
            chk("rwe_out", 64'(reg_write_enable_out), 64'(exp_o.we));
            chk("pc_out", pc_out, exp_o.pc);
            chk("trap_out", 64'(trap_out), 64'(exp_o.trap));
            chk("trap_cause", 64'(trap_cause_out), 64'(exp_o.cause));
            chk("trap_val", trap_val_out, exp_o.tval);
        end
    end

    // g = cycles of gnt delay, v = cycles from grant to rvalid beyond the minimum
    task automatic run_txn(input in_t i, input int g, input int v, input logic [63:0] rdata,
                           input logic err, input int flush_at, input logic stray);
        bus_t b;
        out_t o;
        int n;
        logic [63:0] pc;
        pc = 64'h8000_0000 + 64'(txn_id * 4);
        txn_id++;
        model(i, pc, rdata, err, flush_at >= 0, b, o);
        n = b.bus ? g + v + 2 : 1;
        stall_cnt = 0;
        req_cnt = 0;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk);
            #1;
            if (c < n) drive(i, pc, i.flush || (b.bus && c == flush_at));
            else drive('0, 64'd0, 1'b0);
            dmem_gnt    = b.bus && c == g;
            dmem_rvalid = (b.bus && c == g + 1 + v) || (stray && c == 0);
            dmem_rdata  = dmem_rvalid ? rdata : 64'd0;
            dmem_err    = b.bus && c == g + 1 + v && err;
            exp_req     = b.bus && c <= g;
            exp_b       = b;
            exp_stall   = b.bus && c < g + 1 + v;
            exp_o       = (c == n) ? o : '0;
        end
        $display("txn %0d: alu=%h f3=%0d mr=%0b mw=%0b -> wb=%h trap=%0b cause=%0d", txn_id - 1,
                 i.alu, i.f3, i.mr, i.mw, wb_data, trap_out, trap_cause_out);
    endtask

    initial begin
        in_t t;
        logic [63:0] hw;
        reset = 1'b1;
        drive('0, 64'd0, 1'b0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_b = '0; exp_o = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_data", wb_data, 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        chk("reset_trap", 64'(trap_out), 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        t = mk(64'h1234, 64'd0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0);
        run_txn(t, 0, 0, 64'd0, 1'b0, -1, 1'b1);
        chk("lit_nonmem_wb", wb_data, 64'h1234);
        chk("lit_nonmem_rd", 64'(rd_out), 64'd5);
        chk("lit_nonmem_stall", 64'(stall_cnt), 64'd0);

        t = mk(64'h1003, 64'd0, 5'd7, 3'b000, 1'b1, 1'b1, 1'b0);
        run_txn(t, 0, 0, 64'h0000_0000_8000_0000, 1'b0, -1, 1'b0);
        chk("lit_lb_wb", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lit_lb_stall", 64'(stall_cnt), 64'd1);

        t.f3 = 3'b100;
        run_txn(t, 0, 0, 64'h0000_0000_8000_0000, 1'b0, -1, 1'b0);
        chk("lit_lbu_wb", wb_data, 64'h80);

        t = mk(64'h2006, 64'hABCD, 5'd9, 3'b001, 1'b1, 1'b0, 1'b1);
        run_txn(t, 3, 0, 64'd0, 1'b0, -1, 1'b0);
        hw = last_wdata;
        chk("lit_sh_be", 64'(last_be), 64'hC0);
        chk("lit_sh_wdata", 64'(hw[63:48]), 64'hABCD);
        chk("lit_sh_req_cycles", 64'(req_cnt), 64'd4);
        chk("lit_sh_rwe", 64'(reg_write_enable_out), 64'd0);

        t = mk(64'h3002, 64'd0, 5'd4, 3'b010, 1'b1, 1'b1, 1'b0);
        run_txn(t, 0, 0, 64'd0, 1'b0, -1, 1'b0);
        chk("lit_lw_mis_trap", 64'(trap_out), 64'd1);
        chk("lit_lw_mis_cause", 64'(trap_cause_out), 64'd4);
        chk("lit_lw_mis_tval", trap_val_out, 64'h3002);
        chk("lit_lw_mis_noreq", 64'(req_cnt), 64'd0);

        t = mk(64'h3004, 64'h55, 5'd0, 3'b011, 1'b0, 1'b0, 1'b1);
        run_txn(t, 0, 0, 64'd0, 1'b0, -1, 1'b0);
        chk("lit_sd_mis_cause", 64'(trap_cause_out), 64'd6);

        t = mk(64'h4000, 64'd0, 5'd10, 3'b011, 1'b1, 1'b1, 1'b0);
        run_txn(t, 1, 1, 64'hDEAD, 1'b1, -1, 1'b0);
        chk("lit_ld_err_trap", 64'(trap_out), 64'd1);
        chk("lit_ld_err_cause", 64'(trap_cause_out), 64'd5);
        chk("lit_ld_err_rwe", 64'(reg_write_enable_out), 64'd0);

        t = mk(64'h5000, 64'd0, 5'd11, 3'b010, 1'b1, 1'b1, 1'b0);
        run_txn(t, 2, 0, 64'h1111, 1'b0, 1, 1'b0);
        chk("lit_flush_rwe", 64'(reg_write_enable_out), 64'd0);
        chk("lit_flush_req_cycles", 64'(req_cnt), 64'd3);

        t = mk(64'h6002, 64'd0, 5'd12, 3'b001, 1'b1, 1'b1, 1'b0);
        run_txn(t, 0, 1, 64'h0000_0000_9ABC_0000, 1'b0, -1, 1'b0);
        t.f3 = 3'b101;
        run_txn(t, 1, 0, 64'h0000_0000_9ABC_0000, 1'b0, -1, 1'b0);
        t = mk(64'h7004, 64'd0, 5'd13, 3'b010, 1'b1, 1'b1, 1'b0);
        run_txn(t, 0, 0, 64'h8765_4321_0000_0000, 1'b0, -1, 1'b0);
        t.f3 = 3'b110;
        run_txn(t, 0, 0, 64'h8765_4321_0000_0000, 1'b0, -1, 1'b0);
        t = mk(64'h8000, 64'd0, 5'd14, 3'b011, 1'b1, 1'b1, 1'b0);
        run_txn(t, 0, 2, 64'h0123_4567_89AB_CDEF, 1'b0, -1, 1'b0);
        t = mk(64'h8005, 64'h77, 5'd15, 3'b000, 1'b0, 1'b0, 1'b1);
        run_txn(t, 1, 0, 64'd0, 1'b0, -1, 1'b0);
        t = mk(64'h7004, 64'hCAFE_F00D, 5'd16, 3'b010, 1'b0, 1'b0, 1'b1);
        run_txn(t, 0, 0, 64'd0, 1'b1, -1, 1'b0);
        t = mk(64'h9000, 64'd0, 5'd17, 3'b111, 1'b1, 1'b1, 1'b0);
        run_txn(t, 0, 0, 64'd0, 1'b0, -1, 1'b0);
        t = mk(64'h9008, 64'd0, 5'd18, 3'b011, 1'b1, 1'b1, 1'b0);
        t.trap = 1'b1; t.cause = 4'd2;
        run_txn(t, 0, 0, 64'd0, 1'b0, -1, 1'b0);
        t = mk(64'h9010, 64'd0, 5'd19, 3'b011, 1'b1, 1'b1, 1'b0);
        t.flush = 1'b1;
        run_txn(t, 0, 0, 64'd0, 1'b0, -1, 1'b0);

        // Reset while waiting for rvalid
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(64'hA000, 64'd0, 5'd20, 3'b011, 1'b1, 1'b1, 1'b0), 64'h100, 1'b0);
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        chk("resp_stall_before_reset", 64'(stall_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wb", wb_data, 64'd0);
        chk("rst_rwe", 64'(reg_write_enable_out), 64'd0);
        chk("rst_pc", pc_out, 64'd0);
        chk("rst_trap", 64'(trap_out), 64'd0);
        chk("rst_tval", trap_val_out, 64'd0);
        drive('0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_b = '0; exp_o = '0;
        chk_en = 1'b1;

        t = mk(64'h5555, 64'd0, 5'd21, 3'd0, 1'b1, 1'b0, 1'b0);
        run_txn(t, 0, 0, 64'd0, 1'b0, -1, 1'b0);
        chk("lit_after_reset_wb", wb_data, 64'h5555);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
